// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bundle of the MPU, renderer and VRAM bus signals that
// the VRAM arbiter sits between.
//   MPU side      : mpu_exclusive, mpu_req/wr/be/addr/wdata -> mpu_ack/rdata/rvalid
//   Renderer side : ren_req/addr -> ren_ack/rdata/rvalid
//   VRAM side     : vram_en/rd/wr/be/addr/data_out -> vram_data_in
// Modports: slave = the arbiter, master = requesters plus the memory.
interface vram_arbiter_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16
);
    logic                  mpu_exclusive;
    logic                  mpu_req;
    logic                  mpu_wr;
    logic [1:0]            mpu_be;
    logic [ADDR_WIDTH-1:0] mpu_addr;
    logic [DATA_WIDTH-1:0] mpu_wdata;
    logic                  mpu_ack;
    logic [DATA_WIDTH-1:0] mpu_rdata;
    logic                  mpu_rvalid;

    logic                  ren_req;
    logic [ADDR_WIDTH-1:0] ren_addr;
    logic                  ren_ack;
    logic [DATA_WIDTH-1:0] ren_rdata;
    logic                  ren_rvalid;

    logic                  vram_en;
    logic                  vram_rd;
    logic                  vram_wr;
    logic [1:0]            vram_be;
    logic [ADDR_WIDTH-1:0] vram_addr;
    logic [DATA_WIDTH-1:0] vram_data_out;
    logic [DATA_WIDTH-1:0] vram_data_in;

    modport slave (
        input  mpu_exclusive, mpu_req, mpu_wr, mpu_be, mpu_addr, mpu_wdata,
        input  ren_req, ren_addr, vram_data_in,
        output mpu_ack, mpu_rdata, mpu_rvalid,
        output ren_ack, ren_rdata, ren_rvalid,
        output vram_en, vram_rd, vram_wr, vram_be, vram_addr, vram_data_out
    );

    modport master (
        output mpu_exclusive, mpu_req, mpu_wr, mpu_be, mpu_addr, mpu_wdata,
        output ren_req, ren_addr, vram_data_in,
        input  mpu_ack, mpu_rdata, mpu_rvalid,
        input  ren_ack, ren_rdata, ren_rvalid,
        input  vram_en, vram_rd, vram_wr, vram_be, vram_addr, vram_data_out
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port VRAM between the MPU and the renderer.
// Ports:
//   clk    - system clock
//   _reset - asynchronous active-low reset
//   bus    - vram_arbiter_if.slave (MPU, renderer and VRAM signals)
// Acks are combinational; the VRAM command is registered one cycle after
// the transfer edge, memory answers one cycle later, and the read data is
// registered into the owner's rdata/rvalid (rvalid in the 3rd cycle after
// the transfer edge). The renderer has priority, but after MAX_REN_BURST
// back-to-back renderer transfers a waiting MPU is forced in.
module vram_arbiter #(
    parameter int ADDR_WIDTH    = 20,
    parameter int DATA_WIDTH    = 16,
    parameter int MAX_REN_BURST = 8
) (
    input  logic            clk,
    input  logic            _reset,
    vram_arbiter_if.slave   bus
);

    localparam logic [7:0] BURST_MAX = 8'(MAX_REN_BURST);

    // Owner tag of an in-flight access; only read tags produce an rvalid.
    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_MPU_RD = 2'd1,
        TAG_MPU_WR = 2'd2,
        TAG_REN_RD = 2'd3
    } tag_t;

    logic                  mpu_ack;
    logic                  ren_ack;
    logic                  forced_mpu;

    logic [7:0]            burst_cnt_reg;
    tag_t                  tag1_reg;
    tag_t                  tag2_reg;

    logic                  vram_en_reg;
    logic                  vram_rd_reg;
    logic                  vram_wr_reg;
    logic [1:0]            vram_be_reg;
    logic [ADDR_WIDTH-1:0] vram_addr_reg;
    logic [DATA_WIDTH-1:0] vram_data_out_reg;

    logic [DATA_WIDTH-1:0] mpu_rdata_reg;
    logic                  mpu_rvalid_reg;
    logic [DATA_WIDTH-1:0] ren_rdata_reg;
    logic                  ren_rvalid_reg;

    // Grant decode. Gated by reset so no ack is visible while held in reset.
    always_comb begin
        forced_mpu = (burst_cnt_reg == BURST_MAX) && bus.mpu_req;
        mpu_ack    = 1'b0;
        ren_ack    = 1'b0;
        if (_reset) begin
            if (bus.mpu_exclusive) begin
                mpu_ack = bus.mpu_req;
            end else begin
                ren_ack = bus.ren_req && !forced_mpu;
                // MPU wins whenever the renderer is not granted this cycle.
                mpu_ack = bus.mpu_req && !ren_ack;
            end
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            burst_cnt_reg     <= '0;
            tag1_reg          <= TAG_NONE;
            tag2_reg          <= TAG_NONE;
            vram_en_reg       <= 1'b0;
            vram_rd_reg       <= 1'b0;
            vram_wr_reg       <= 1'b0;
            vram_be_reg       <= '0;
            vram_addr_reg     <= '0;
            vram_data_out_reg <= '0;
            mpu_rdata_reg     <= '0;
            mpu_rvalid_reg    <= 1'b0;
            ren_rdata_reg     <= '0;
            ren_rvalid_reg    <= 1'b0;
        end else begin
            // Burst counter: counts consecutive renderer transfers only.
            if (bus.mpu_exclusive || !ren_ack) begin
                burst_cnt_reg <= '0;
            end else if (burst_cnt_reg != BURST_MAX) begin
                burst_cnt_reg <= burst_cnt_reg + 8'd1;
            end

            // Stage 1: VRAM command for the transfer just accepted.
            if (ren_ack) begin
                vram_en_reg       <= 1'b1;
                vram_rd_reg       <= 1'b1;
                vram_wr_reg       <= 1'b0;
                vram_be_reg       <= 2'b11;
                vram_addr_reg     <= bus.ren_addr;
                vram_data_out_reg <= '0;
                tag1_reg          <= TAG_REN_RD;
            end else if (mpu_ack) begin
                vram_en_reg       <= 1'b1;
                vram_rd_reg       <= !bus.mpu_wr;
                vram_wr_reg       <= bus.mpu_wr;
                vram_be_reg       <= bus.mpu_be;
                vram_addr_reg     <= bus.mpu_addr;
                vram_data_out_reg <= bus.mpu_wdata;
                tag1_reg          <= bus.mpu_wr ? TAG_MPU_WR : TAG_MPU_RD;
            end else begin
                // Address and write data intentionally hold their last value.
                vram_en_reg       <= 1'b0;
                vram_rd_reg       <= 1'b0;
                vram_wr_reg       <= 1'b0;
                vram_be_reg       <= '0;
                tag1_reg          <= TAG_NONE;
            end

            // Stage 2: memory is returning data for the tag now in tag2.
            tag2_reg <= tag1_reg;

            // Route the returned data by the tag that travelled with the
            // access, never by the current mpu_exclusive setting.
            mpu_rvalid_reg <= (tag2_reg == TAG_MPU_RD);
            ren_rvalid_reg <= (tag2_reg == TAG_REN_RD);
            if (tag2_reg == TAG_MPU_RD) begin
                mpu_rdata_reg <= bus.vram_data_in;
            end
            if (tag2_reg == TAG_REN_RD) begin
                ren_rdata_reg <= bus.vram_data_in;
            end
        end
    end

    assign bus.mpu_ack       = mpu_ack;
    assign bus.ren_ack       = ren_ack;
    assign bus.mpu_rdata     = mpu_rdata_reg;
    assign bus.mpu_rvalid    = mpu_rvalid_reg;
    assign bus.ren_rdata     = ren_rdata_reg;
    assign bus.ren_rvalid    = ren_rvalid_reg;
    assign bus.vram_en       = vram_en_reg;
    assign bus.vram_rd       = vram_rd_reg;
    assign bus.vram_wr       = vram_wr_reg;
    assign bus.vram_be       = vram_be_reg;
    assign bus.vram_addr     = vram_addr_reg;
    assign bus.vram_data_out = vram_data_out_reg;

endmodule
